// File: rtl/scalar_uesprit_ctrl_pkg.sv
// Shared types for the U-ESPRIT correlation controller: FSM encoding and small helpers.
package scalar_uesprit_ctrl_pkg;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_STOP_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_STOP = ST_STOP_ENC
  } state_t;

  function automatic logic is_active(state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/scalar_uesprit_ctrl_if.sv
// Result bus between the correlation datapath, the output buffer and the consumer.
interface scalar_uesprit_ctrl_if #(
  parameter int DOUT_WIDTH = 32
);
  logic [DOUT_WIDTH-1:0] res_r11;
  logic [DOUT_WIDTH-1:0] res_r22;
  logic [DOUT_WIDTH-1:0] res_r12_re;
  logic [DOUT_WIDTH-1:0] res_r12_im;
  logic                  res_valid;
  logic [DOUT_WIDTH-1:0] r11;
  logic [DOUT_WIDTH-1:0] r22;
  logic [DOUT_WIDTH-1:0] r12_re;
  logic [DOUT_WIDTH-1:0] r12_im;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  overflow;
  logic                  captured;

  modport master (
    output res_r11, res_r22, res_r12_re, res_r12_im, res_valid, dout_ready,
    input  r11, r22, r12_re, r12_im, dout_valid, overflow, captured
  );

  modport slave (
    input  res_r11, res_r22, res_r12_re, res_r12_im, res_valid, dout_ready,
    output r11, r22, r12_re, r12_im, dout_valid, overflow, captured
  );
endinterface

// File: rtl/scalar_uesprit_ctrl_result_skid_buf.sv
// Single-entry result buffer with valid/ready handshake and a sticky drop flag.
module result_skid_buf
  import scalar_uesprit_ctrl_pkg::*;
#(
  parameter int DOUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  scalar_uesprit_ctrl_if.slave bus
);

  logic [DOUT_WIDTH-1:0] r11_q, r11_d;
  logic [DOUT_WIDTH-1:0] r22_q, r22_d;
  logic [DOUT_WIDTH-1:0] r12_re_q, r12_re_d;
  logic [DOUT_WIDTH-1:0] r12_im_q, r12_im_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  capture;

  always_comb begin
    r11_d        = r11_q;
    r22_d        = r22_q;
    r12_re_d     = r12_re_q;
    r12_im_d     = r12_im_q;
    dout_valid_d = dout_valid_q;
    overflow_d   = overflow_q;
    capture      = 1'b0;
    if (bus.res_valid) begin
      // A held, unaccepted result wins over the newcomer.
      if (dout_valid_q && !bus.dout_ready) begin
        overflow_d = 1'b1;
      end else begin
        r11_d        = bus.res_r11;
        r22_d        = bus.res_r22;
        r12_re_d     = bus.res_r12_re;
        r12_im_d     = bus.res_r12_im;
        dout_valid_d = 1'b1;
        capture      = 1'b1;
      end
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r11_q        <= '0;
      r22_q        <= '0;
      r12_re_q     <= '0;
      r12_im_q     <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      r11_q        <= r11_d;
      r22_q        <= r22_d;
      r12_re_q     <= r12_re_d;
      r12_im_q     <= r12_im_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.r11        = r11_q;
  assign bus.r22        = r22_q;
  assign bus.r12_re     = r12_re_q;
  assign bus.r12_im     = r12_im_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.captured   = capture;

endmodule

// File: rtl/scalar_uesprit_ctrl.sv
// Frame controller for the scalar U-ESPRIT correlator: counts samples into frames,
// pulses new_acc at frame ends, drops the stale first result and buffers the rest.
module scalar_uesprit_ctrl
  import scalar_uesprit_ctrl_pkg::*;
#(
  parameter int DOUT_WIDTH      = 32,
  parameter int ACC_LEN_WIDTH   = 16,
  parameter int FRAME_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [ACC_LEN_WIDTH-1:0]   cfg_acc_len,
  input  logic                       cfg_write,
  input  logic                       din_valid,
  output logic                       new_acc,
  input  logic [DOUT_WIDTH-1:0]      res_r11,
  input  logic [DOUT_WIDTH-1:0]      res_r22,
  input  logic [DOUT_WIDTH-1:0]      res_r12_re,
  input  logic [DOUT_WIDTH-1:0]      res_r12_im,
  input  logic                       res_valid,
  output logic [DOUT_WIDTH-1:0]      r11,
  output logic [DOUT_WIDTH-1:0]      r22,
  output logic [DOUT_WIDTH-1:0]      r12_re,
  output logic [DOUT_WIDTH-1:0]      r12_im,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       overflow,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt
);

  localparam logic [ACC_LEN_WIDTH-1:0]   ACC_ONE   = 1;
  localparam logic [FRAME_CNT_WIDTH-1:0] FRAME_ONE = 1;

  state_t                     state_q, state_d;
  logic [ACC_LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ACC_LEN_WIDTH-1:0]   act_len_q, act_len_d;
  logic [ACC_LEN_WIDTH-1:0]   pend_len_q, pend_len_d;
  logic                       discard_q, discard_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic                       frame_end;

  scalar_uesprit_ctrl_if #(.DOUT_WIDTH(DOUT_WIDTH)) rbus ();

  assign rbus.res_r11    = res_r11;
  assign rbus.res_r22    = res_r22;
  assign rbus.res_r12_re = res_r12_re;
  assign rbus.res_r12_im = res_r12_im;
  assign rbus.res_valid  = res_valid && !discard_q;
  assign rbus.dout_ready = dout_ready;

  result_skid_buf #(.DOUT_WIDTH(DOUT_WIDTH)) u_buf (
    .clk (clk),
    .rst (rst),
    .bus (rbus.slave)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_len_d   = act_len_q;
    pend_len_d  = pend_len_q;
    discard_d   = discard_q;
    frame_cnt_d = frame_cnt_q;
    frame_end   = is_active(state_q) && din_valid && (cnt_q == act_len_q - ACC_ONE);

    if (cfg_write) pend_len_d = cfg_acc_len;

    if (is_active(state_q) && din_valid) begin
      if (frame_end) begin
        cnt_d     = '0;
        act_len_d = pend_len_q;
      end else begin
        cnt_d = cnt_q + ACC_ONE;
      end
    end

    if (res_valid && discard_q) discard_d = 1'b0;
    if (rbus.captured) frame_cnt_d = frame_cnt_q + FRAME_ONE;

    unique case (state_q)
      ST_IDLE: begin
        if (en && (pend_len_q != '0)) begin
          state_d   = ST_RUN;
          act_len_d = pend_len_q;
          cnt_d     = '0;
          discard_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) state_d = ST_STOP;
      end
      ST_STOP: begin
        // A finishing frame takes priority over a same-cycle re-enable.
        if (frame_end)  state_d = ST_IDLE;
        else if (en)    state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      act_len_q   <= '0;
      pend_len_q  <= '0;
      discard_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_len_q   <= act_len_d;
      pend_len_q  <= pend_len_d;
      discard_q   <= discard_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Reset aborts a frame in the same cycle, so the pulse is masked combinationally.
  assign new_acc    = frame_end && !rst;
  assign busy       = is_active(state_q);
  assign frame_cnt  = frame_cnt_q;
  assign r11        = rbus.r11;
  assign r22        = rbus.r22;
  assign r12_re     = rbus.r12_re;
  assign r12_im     = rbus.r12_im;
  assign dout_valid = rbus.dout_valid;
  assign overflow   = rbus.overflow;

endmodule

// File: tb/tb_scalar_uesprit_ctrl.sv
// Directed and table-driven bench for scalar_uesprit_ctrl with a result scoreboard.
module tb_scalar_uesprit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] cfg_acc_len;
  logic        cfg_write;
  logic        din_valid;
  logic        new_acc;
  logic        busy;
  logic [31:0] frame_cnt;

  scalar_uesprit_ctrl_if #(.DOUT_WIDTH(32)) rb ();

  scalar_uesprit_ctrl #(
    .DOUT_WIDTH(32), .ACC_LEN_WIDTH(16), .FRAME_CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_acc_len(cfg_acc_len), .cfg_write(cfg_write),
    .din_valid(din_valid), .new_acc(new_acc),
    .res_r11(rb.res_r11), .res_r22(rb.res_r22), .res_r12_re(rb.res_r12_re),
    .res_r12_im(rb.res_r12_im), .res_valid(rb.res_valid),
    .r11(rb.r11), .r22(rb.r22), .r12_re(rb.r12_re), .r12_im(rb.r12_im),
    .dout_valid(rb.dout_valid), .dout_ready(rb.dout_ready), .overflow(rb.overflow),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, c, d;
  } words_t;

  typedef struct {
    bit          rv;
    bit          rdy;
    bit          cap;
    bit          exp_dv;
    bit          exp_ovf;
    logic [31:0] exp_fc;
  } vec_t;

  words_t sb[$];
  int     n_tot = 0;
  int     n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(bit dv, bit exp_na, string nm);
    din_valid = dv;
    #1;
    chk(nm, 64'(new_acc), 64'(exp_na));
    tick();
  endtask

  task automatic chk_words(string nm, words_t e);
    chk({nm, "_r11"}, 64'(rb.r11), 64'(e.a));
    chk({nm, "_r22"}, 64'(rb.r22), 64'(e.b));
    chk({nm, "_re"},  64'(rb.r12_re), 64'(e.c));
    chk({nm, "_im"},  64'(rb.r12_im), 64'(e.d));
  endtask

  task automatic drive_words(bit push);
    words_t w;
    w.a = $urandom; w.b = $urandom; w.c = $urandom; w.d = $urandom;
    rb.res_r11 = w.a; rb.res_r22 = w.b; rb.res_r12_re = w.c; rb.res_r12_im = w.d;
    if (push) sb.push_back(w);
  endtask

  task automatic res_pulse(bit push);
    drive_words(push);
    rb.res_valid = 1'b1;
    tick();
    rb.res_valid = 1'b0;
  endtask

  task automatic drain(string nm);
    words_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'(1), 64'(0));
    end else begin
      e = sb.pop_front();
      chk_words(nm, e);
    end
    rb.dout_ready = 1'b1;
    tick();
    rb.dout_ready = 1'b0;
    chk({nm, "_dv_clr"}, 64'(rb.dout_valid), 64'(0));
  endtask

  vec_t vt[10];
  int   k;

  initial begin
    vt[0] = '{1, 0, 1, 1, 0, 1};
    vt[1] = '{0, 0, 0, 1, 0, 1};
    vt[2] = '{1, 1, 1, 1, 0, 2};
    vt[3] = '{0, 1, 0, 0, 0, 2};
    vt[4] = '{1, 1, 1, 1, 0, 3};
    vt[5] = '{1, 0, 0, 1, 1, 3};
    vt[6] = '{0, 0, 0, 1, 1, 3};
    vt[7] = '{0, 1, 0, 0, 1, 3};
    vt[8] = '{1, 0, 1, 1, 1, 4};
    vt[9] = '{0, 1, 0, 0, 1, 4};

    rst = 1'b1; en = 1'b0; cfg_acc_len = '0; cfg_write = 1'b0; din_valid = 1'b0;
    rb.res_valid = 1'b0; rb.dout_ready = 1'b0; rb.captured = 1'b0;
    rb.res_r11 = '0; rb.res_r22 = '0; rb.res_r12_re = '0; rb.res_r12_im = '0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dv", 64'(rb.dout_valid), 64'(0));
    chk("rst_ovf", 64'(rb.overflow), 64'(0));
    chk("rst_fc", 64'(frame_cnt), 64'(0));
    chk("rst_r11", 64'(rb.r11), 64'(0));
    chk("rst_na", 64'(new_acc), 64'(0));
    rst = 1'b0;

    // Length 4, continuous samples, discard then capture then overflow
    cfg_acc_len = 16'd4; cfg_write = 1'b1; tick(); cfg_write = 1'b0;
    en = 1'b1; tick();
    chk("s1_busy", 64'(busy), 64'(1));
    for (int i = 1; i <= 12; i++) smp(1'b1, (i % 4) == 0, "s1_new_acc");
    din_valid = 1'b0;
    res_pulse(1'b0);
    chk("s1_discard_dv", 64'(rb.dout_valid), 64'(0));
    chk("s1_discard_fc", 64'(frame_cnt), 64'(0));
    res_pulse(1'b1);
    chk("s1_cap_dv", 64'(rb.dout_valid), 64'(1));
    chk("s1_cap_fc", 64'(frame_cnt), 64'(1));
    chk_words("s1_cap", sb[0]);
    res_pulse(1'b0);
    chk("s4_ovf", 64'(rb.overflow), 64'(1));
    chk("s4_fc", 64'(frame_cnt), 64'(1));
    chk("s4_dv", 64'(rb.dout_valid), 64'(1));
    drain("s4_hold");

    // Sparse samples: pulse only on every 4th valid sample
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if ((i % 2) == 0) k++;
      smp((i % 2) == 0, ((i % 2) == 0) && ((k % 4) == 0), "s2_new_acc");
    end

    // Length change mid-frame takes effect at the next boundary
    smp(1'b1, 1'b0, "s3_a");
    smp(1'b1, 1'b0, "s3_a");
    cfg_acc_len = 16'd8; cfg_write = 1'b1;
    smp(1'b0, 1'b0, "s3_wr");
    cfg_write = 1'b0;
    smp(1'b1, 1'b0, "s3_a");
    smp(1'b1, 1'b1, "s3_a_end");
    cfg_acc_len = 16'd4; cfg_write = 1'b1;
    smp(1'b0, 1'b0, "s3_wr");
    cfg_write = 1'b0;
    for (int i = 1; i <= 8; i++) smp(1'b1, i == 8, "s3_b");

    // Stop then resume before the frame ends
    smp(1'b1, 1'b0, "sr_a");
    en = 1'b0;
    smp(1'b0, 1'b0, "sr_stop");
    chk("sr_busy_stop", 64'(busy), 64'(1));
    en = 1'b1;
    smp(1'b0, 1'b0, "sr_resume");
    smp(1'b1, 1'b0, "sr_b");
    smp(1'b1, 1'b0, "sr_b");
    smp(1'b1, 1'b1, "sr_end");
    chk("sr_busy_run", 64'(busy), 64'(1));

    // Stop after 2 of 4 samples: frame completes, then idle
    smp(1'b1, 1'b0, "s6_a");
    smp(1'b1, 1'b0, "s6_a");
    en = 1'b0;
    smp(1'b0, 1'b0, "s6_stop");
    chk("s6_busy_stop", 64'(busy), 64'(1));
    smp(1'b1, 1'b0, "s6_b");
    smp(1'b1, 1'b1, "s6_end");
    chk("s6_busy_idle", 64'(busy), 64'(0));
    for (int i = 0; i < 6; i++) smp(1'b1, 1'b0, "s6_idle_na");
    din_valid = 1'b0;
    res_pulse(1'b1);
    chk("s6_idle_cap_dv", 64'(rb.dout_valid), 64'(1));
    chk("s6_idle_cap_fc", 64'(frame_cnt), 64'(2));
    drain("s6_idle");

    // Reset mid-frame aborts without a pulse and clears configuration
    en = 1'b1; tick();
    smp(1'b1, 1'b0, "s7_a");
    smp(1'b1, 1'b0, "s7_a");
    smp(1'b1, 1'b0, "s7_a");
    rst = 1'b1; din_valid = 1'b1;
    #1;
    chk("s7_rst_na", 64'(new_acc), 64'(0));
    tick();
    rst = 1'b0; din_valid = 1'b0;
    chk("s7_busy", 64'(busy), 64'(0));
    chk("s7_fc", 64'(frame_cnt), 64'(0));
    chk("s7_ovf", 64'(rb.overflow), 64'(0));
    tick(); tick();
    chk("s7_zero_len_idle", 64'(busy), 64'(0));

    // Re-enable after reset discards the first result again
    cfg_acc_len = 16'd4; cfg_write = 1'b1; tick(); cfg_write = 1'b0;
    tick();
    chk("s8_busy", 64'(busy), 64'(1));
    res_pulse(1'b0);
    chk("s8_discard_dv", 64'(rb.dout_valid), 64'(0));
    chk("s8_discard_fc", 64'(frame_cnt), 64'(0));
    res_pulse(1'b1);
    chk("s8_cap_dv", 64'(rb.dout_valid), 64'(1));
    chk("s8_cap_fc", 64'(frame_cnt), 64'(1));
    drain("s8");

    // Length 1: every valid sample ends a frame
    cfg_acc_len = 16'd1; cfg_write = 1'b1;
    smp(1'b0, 1'b0, "l1_wr");
    cfg_write = 1'b0;
    for (int i = 1; i <= 4; i++) smp(1'b1, i == 4, "l1_prev");
    smp(1'b1, 1'b1, "l1_na");
    smp(1'b0, 1'b0, "l1_gap");
    smp(1'b1, 1'b1, "l1_na");
    smp(1'b1, 1'b1, "l1_na");
    din_valid = 1'b0;

    // Buffer handshake table, run from a fresh reset in IDLE
    en = 1'b0; rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 10; i++) begin
      if (vt[i].rdy && rb.dout_valid) begin
        if (sb.size() == 0) chk($sformatf("tv%0d_sb", i), 64'(1), 64'(0));
        else chk_words($sformatf("tv%0d_acc", i), sb.pop_front());
      end
      drive_words(vt[i].cap);
      rb.res_valid  = vt[i].rv;
      rb.dout_ready = vt[i].rdy;
      tick();
      rb.res_valid  = 1'b0;
      rb.dout_ready = 1'b0;
      chk($sformatf("tv%0d_dv", i), 64'(rb.dout_valid), 64'(vt[i].exp_dv));
      chk($sformatf("tv%0d_ovf", i), 64'(rb.overflow), 64'(vt[i].exp_ovf));
      chk($sformatf("tv%0d_fc", i), 64'(frame_cnt), 64'(vt[i].exp_fc));
      if (vt[i].exp_dv && sb.size() > 0) chk_words($sformatf("tv%0d_hold", i), sb[0]);
    end
    chk("sb_left", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
